// File: rtl/segment_transition_ctl.sv
// -----------------------------------------------------------------------------
// segment_transition_ctl
//
// Chooses which of the two segments of a double-buffered sequencer (modulation
// or STM) is being read. A segment-change request from the register file is
// latched on UPDATE. The controller then waits for the requested transition
// condition before switching. Completed loops of the active segment are
// counted against its repeat count. A finite repeat count that runs out either
// raises STOP, or, after an EXT transition, swaps automatically to the other
// segment.
//
// Ports
//   CLK               system clock
//   RST               synchronous active-high reset
//   UPDATE            one-cycle pulse, samples REQ_SEGMENT / TRANSITION_MODE /
//                     TRANSITION_VALUE
//   REQ_SEGMENT       requested read segment
//   REP0, REP1        repeat count per segment (loops = REP+1, all-ones = forever)
//   TRANSITION_MODE   0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT
//   TRANSITION_VALUE  target time (SYS_TIME) or GPIO pin select in [1:0]
//   SYS_TIME          free-running system time
//   GPIO_IN           synchronized GPIO inputs
//   LOOP_END          index counter wrapped on the active segment
//   SEGMENT           active read segment
//   SWAP              one-cycle pulse on a segment change or a restart
//   STOP              finite repeats exhausted
//   BUSY              a transition is pending
//   LOOP_CNT          completed loops of the active segment
// -----------------------------------------------------------------------------
module segment_transition_ctl #(
    parameter int RepWidth  = 16,
    parameter int TimeWidth = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 UPDATE,
    input  logic                 REQ_SEGMENT,
    input  logic [RepWidth-1:0]  REP0,
    input  logic [RepWidth-1:0]  REP1,
    input  logic [7:0]           TRANSITION_MODE,
    input  logic [TimeWidth-1:0] TRANSITION_VALUE,
    input  logic [TimeWidth-1:0] SYS_TIME,
    input  logic [3:0]           GPIO_IN,
    input  logic                 LOOP_END,
    output logic                 SEGMENT,
    output logic                 SWAP,
    output logic                 STOP,
    output logic                 BUSY,
    output logic [RepWidth-1:0]  LOOP_CNT
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_SYNC_IDX = 2'd0,
        MODE_SYS_TIME = 2'd1,
        MODE_GPIO     = 2'd2,
        MODE_EXT      = 2'd3
    } mode_t;

    localparam logic [RepWidth-1:0] RepInfinite = '1;
    localparam logic [RepWidth-1:0] RepOne      = RepWidth'(1);

    state_t               state_reg;
    mode_t                mode_reg;
    logic                 segment_reg;
    logic                 swap_reg;
    logic                 stop_reg;
    logic                 busy_reg;
    logic                 ext_reg;
    logic                 target_reg;
    logic                 gpio_prev_reg;
    logic [RepWidth-1:0]  loop_cnt_reg;
    logic [RepWidth-1:0]  rep_reg;
    logic [TimeWidth-1:0] value_reg;

    mode_t                req_mode;
    logic                 req_mode_valid;
    logic                 update_ok;
    logic                 pin_now;
    logic                 trig_cond;
    logic                 trigger;
    logic                 seg_done;
    logic                 other_seg;
    logic [RepWidth-1:0]  rep_sel [2];

    // Repeat count lookup indexed by segment number.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rep_sel
            assign rep_sel[gi] = (gi == 0) ? REP0 : REP1;
        end
    endgenerate

    always_comb begin
        req_mode       = MODE_SYNC_IDX;
        req_mode_valid = 1'b1;
        case (TRANSITION_MODE)
            8'h00:   req_mode = MODE_SYNC_IDX;
            8'h01:   req_mode = MODE_SYS_TIME;
            8'h02:   req_mode = MODE_GPIO;
            8'hF0:   req_mode = MODE_EXT;
            default: req_mode_valid = 1'b0;
        endcase

        update_ok = UPDATE && req_mode_valid;
        pin_now   = GPIO_IN[value_reg[1:0]];
        other_seg = !segment_reg;

        trig_cond = 1'b0;
        case (mode_reg)
            MODE_SYNC_IDX: trig_cond = LOOP_END || stop_reg;  // a stopped segment never wraps again
            MODE_SYS_TIME: trig_cond = (SYS_TIME >= value_reg);
            MODE_GPIO:     trig_cond = pin_now && !gpio_prev_reg;
            MODE_EXT:      trig_cond = 1'b1;
            default:       trig_cond = 1'b0;
        endcase

        // A fresh valid UPDATE replaces the pending request, so the old one
        // can no longer fire in that cycle.
        trigger  = (state_reg == ST_WAIT) && !update_ok && trig_cond;

        seg_done = LOOP_END && !stop_reg && (rep_reg != RepInfinite)
                   && (loop_cnt_reg == rep_reg);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_RUN;
            mode_reg      <= MODE_SYNC_IDX;
            segment_reg   <= 1'b0;
            swap_reg      <= 1'b0;
            stop_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            ext_reg       <= 1'b0;
            target_reg    <= 1'b0;
            gpio_prev_reg <= 1'b0;
            loop_cnt_reg  <= '0;
            rep_reg       <= RepInfinite;    // segment 0 plays forever until the first UPDATE
            value_reg     <= '0;
        end else begin
            swap_reg      <= 1'b0;
            gpio_prev_reg <= pin_now;

            // Loop accounting for the segment that is playing now.
            if (LOOP_END && !stop_reg) begin
                if (rep_reg == RepInfinite) begin
                    if (loop_cnt_reg != RepInfinite) begin
                        loop_cnt_reg <= loop_cnt_reg + RepOne;
                    end
                end else if (seg_done) begin
                    if (ext_reg) begin
                        // External auto-swap: ping-pong between the segments.
                        segment_reg  <= other_seg;
                        rep_reg      <= rep_sel[other_seg];
                        loop_cnt_reg <= '0;
                        swap_reg     <= 1'b1;
                    end else begin
                        stop_reg <= 1'b1;
                    end
                end else begin
                    loop_cnt_reg <= loop_cnt_reg + RepOne;
                end
            end

            // Request handling; later assignments override the loop accounting.
            if (update_ok) begin
                target_reg    <= REQ_SEGMENT;
                mode_reg      <= req_mode;
                value_reg     <= TRANSITION_VALUE;
                ext_reg       <= 1'b0;
                state_reg     <= ST_WAIT;
                busy_reg      <= 1'b1;
                // Seed the edge detector so a pin that is already high does not fire.
                gpio_prev_reg <= GPIO_IN[TRANSITION_VALUE[1:0]];
            end else if (trigger) begin
                segment_reg  <= target_reg;
                swap_reg     <= 1'b1;
                loop_cnt_reg <= '0;
                stop_reg     <= 1'b0;
                rep_reg      <= rep_sel[target_reg];
                busy_reg     <= 1'b0;
                state_reg    <= ST_RUN;
                ext_reg      <= (mode_reg == MODE_EXT);
            end
        end
    end

    assign SEGMENT  = segment_reg;
    assign SWAP     = swap_reg;
    assign STOP     = stop_reg;
    assign BUSY     = busy_reg;
    assign LOOP_CNT = loop_cnt_reg;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// -----------------------------------------------------------------------------
// Testbench for segment_transition_ctl: directed scenarios followed by a
// randomized run, every cycle compared against a loop-accounting model.
// -----------------------------------------------------------------------------
module tb_segment_transition_ctl;

    localparam int RW  = 16;
    localparam int TW  = 64;
    localparam int INF = 65535;

    logic          clk = 1'b0;
    logic          rst;
    logic          update;
    logic          req_segment;
    logic [RW-1:0] rep0;
    logic [RW-1:0] rep1;
    logic [7:0]    tmode;
    logic [TW-1:0] tval;
    logic [TW-1:0] sys_time;
    logic [3:0]    gpio_in;
    logic          loop_end;
    logic          segment;
    logic          swap;
    logic          stop;
    logic          busy;
    logic [RW-1:0] loop_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model: the active segment, how many loops it has played, its repeat
    // count, and the pending request (if any).
    int              m_seg;
    int              m_played;
    int              m_rep;
    bit              m_ext;
    bit              m_pend;
    bit              m_tgt;
    bit              m_swap;
    bit              m_gpio_last;
    int              m_mode;
    longint unsigned m_val;

    int exp_c[4] = '{1, 2, 2, 2};
    int exp_s[4] = '{0, 0, 1, 1};

    always #5 clk = ~clk;

    segment_transition_ctl #(.RepWidth(RW), .TimeWidth(TW)) dut (
        .CLK              (clk),
        .RST              (rst),
        .UPDATE           (update),
        .REQ_SEGMENT      (req_segment),
        .REP0             (rep0),
        .REP1             (rep1),
        .TRANSITION_MODE  (tmode),
        .TRANSITION_VALUE (tval),
        .SYS_TIME         (sys_time),
        .GPIO_IN          (gpio_in),
        .LOOP_END         (loop_end),
        .SEGMENT          (segment),
        .SWAP             (swap),
        .STOP             (stop),
        .BUSY             (busy),
        .LOOP_CNT         (loop_cnt)
    );

    // Finite segment is stopped once it has played REP+1 loops.
    function automatic bit m_stop_f();
        return (m_rep != INF) && (m_played > m_rep);
    endfunction

    function automatic int m_cnt_f();
        int cap;
        cap = (m_rep == INF) ? INF : m_rep;
        return (m_played > cap) ? cap : m_played;
    endfunction

    task automatic model_clock();
        bit stopped;
        bit valid;
        bit fire;
        int pin;
        m_swap = 1'b0;
        if (rst) begin
            m_seg = 0; m_played = 0; m_rep = INF; m_ext = 0; m_pend = 0; m_gpio_last = 0;
            return;
        end
        stopped = m_stop_f();
        valid   = (tmode == 8'h00) || (tmode == 8'h01) || (tmode == 8'h02) || (tmode == 8'hF0);
        pin     = int'(m_val % 4);
        fire    = 1'b0;
        if (m_pend && !(update && valid)) begin
            case (m_mode)
                0:       fire = loop_end || stopped;
                1:       fire = (sys_time >= m_val);
                2:       fire = gpio_in[pin] && !m_gpio_last;
                240:     fire = 1'b1;
                default: fire = 1'b0;
            endcase
        end
        m_gpio_last = gpio_in[pin];
        if (loop_end && !stopped) m_played++;
        if (m_ext && (m_rep != INF) && (m_played > m_rep)) begin
            m_seg    = 1 - m_seg;
            m_rep    = (m_seg == 1) ? int'(rep1) : int'(rep0);
            m_played = 0;
            m_swap   = 1'b1;
        end
        if (update && valid) begin
            m_pend      = 1'b1;
            m_tgt       = req_segment;
            m_mode      = int'(tmode);
            m_val       = tval;
            m_ext       = 1'b0;
            m_gpio_last = gpio_in[int'(tval % 4)];
        end else if (fire) begin
            m_seg    = int'(m_tgt);
            m_rep    = m_tgt ? int'(rep1) : int'(rep0);
            m_played = 0;
            m_swap   = 1'b1;
            m_pend   = 1'b0;
            if (m_mode == 240) m_ext = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        chk("segment",  64'(segment),  64'(m_seg));
        chk("swap",     64'(swap),     64'(m_swap));
        chk("stop",     64'(stop),     64'(m_stop_f()));
        chk("busy",     64'(busy),     64'(m_pend));
        chk("loop_cnt", 64'(loop_cnt), 64'(m_cnt_f()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; update = 0; req_segment = 0; rep0 = 0; rep1 = 0; tmode = 0;
        tval = 0; sys_time = 0; gpio_in = 0; loop_end = 0;

        // Reset, then segment 0 plays forever.
        tick(); tick();
        chk("rst_segment", 64'(segment), 0);
        chk("rst_stop", 64'(stop), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cnt", 64'(loop_cnt), 0);
        rst = 0;
        for (int i = 0; i < 100; i++) begin
            loop_end = 1; tick(); loop_end = 0; tick();
        end
        chk("inf_stop", 64'(stop), 0);
        chk("inf_cnt", 64'(loop_cnt), 100);

        // SYNC_IDX to segment 1 with three loops.
        rep1 = 2; req_segment = 1; tmode = 8'h00; update = 1; tick(); update = 0;
        for (int i = 1; i < 10; i++) tick();
        chk("sync_busy", 64'(busy), 1);
        chk("sync_seg_wait", 64'(segment), 0);
        loop_end = 1; tick(); loop_end = 0;
        chk("sync_seg", 64'(segment), 1);
        chk("sync_swap", 64'(swap), 1);
        chk("sync_cnt0", 64'(loop_cnt), 0);
        tick();
        chk("sync_swap_clr", 64'(swap), 0);
        for (int i = 0; i < 4; i++) begin
            loop_end = 1; tick(); loop_end = 0;
            chk("sync_loop_cnt", 64'(loop_cnt), 64'(exp_c[i]));
            chk("sync_loop_stop", 64'(stop), 64'(exp_s[i]));
            tick();
        end

        // SYS_TIME: target reached during a ramp.
        rep0 = 5; sys_time = 990; req_segment = 0; tmode = 8'h01; tval = 1000;
        update = 1; tick(); update = 0;
        for (int t = 991; t <= 1000; t++) begin
            sys_time = TW'(t);
            tick();
            if (t == 999) begin
                chk("time_busy", 64'(busy), 1);
                chk("time_seg_wait", 64'(segment), 1);
            end
        end
        chk("time_seg", 64'(segment), 0);
        chk("time_swap", 64'(swap), 1);
        chk("time_busy_clr", 64'(busy), 0);

        // SYS_TIME already in the past.
        sys_time = 1010; rep1 = 3; req_segment = 1; tval = 500;
        update = 1; tick(); update = 0;
        chk("past_seg_u1", 64'(segment), 0);
        chk("past_busy_u1", 64'(busy), 1);
        tick();
        chk("past_seg_u2", 64'(segment), 1);
        chk("past_swap_u2", 64'(swap), 1);

        // GPIO pin 2: already high at UPDATE, other pin toggling.
        gpio_in = 4'b0100; req_segment = 0; tmode = 8'h02; tval = 2;
        update = 1; tick(); update = 0;
        for (int i = 0; i < 6; i++) begin
            gpio_in[1] = ~gpio_in[1];
            tick();
        end
        chk("gpio_hold_seg", 64'(segment), 1);
        chk("gpio_hold_busy", 64'(busy), 1);
        gpio_in[2] = 0; tick();
        chk("gpio_low_seg", 64'(segment), 1);
        gpio_in[2] = 1; tick();
        chk("gpio_seg", 64'(segment), 0);
        chk("gpio_swap", 64'(swap), 1);

        // EXT auto-swap ping-pong.
        rep0 = 0; rep1 = 1; req_segment = 1; tmode = 8'hF0;
        update = 1; tick(); update = 0;
        tick();
        chk("ext_seg", 64'(segment), 1);
        chk("ext_swap", 64'(swap), 1);
        loop_end = 1; tick(); loop_end = 0;
        chk("ext_cnt1", 64'(loop_cnt), 1);
        chk("ext_seg1", 64'(segment), 1);
        tick();
        loop_end = 1; tick(); loop_end = 0;
        chk("ext_auto0", 64'(segment), 0);
        chk("ext_auto0_swap", 64'(swap), 1);
        tick();
        loop_end = 1; tick(); loop_end = 0;
        chk("ext_auto1", 64'(segment), 1);
        chk("ext_stop", 64'(stop), 0);
        tick();

        // Second UPDATE replaces a pending SYNC_IDX request.
        sys_time = 2000; tval = 2005; req_segment = 1; tmode = 8'h00;
        update = 1; tick();
        req_segment = 0; tmode = 8'h01; sys_time = 2001; tick(); update = 0;
        sys_time = 2002; loop_end = 1; tick(); loop_end = 0;
        chk("discard_swap", 64'(swap), 0);
        chk("discard_busy", 64'(busy), 1);
        for (int t = 2003; t <= 2005; t++) begin
            sys_time = TW'(t);
            tick();
        end
        chk("discard_seg", 64'(segment), 0);

        // Undefined mode is ignored.
        tmode = 8'h05; req_segment = 1; update = 1; tick(); update = 0;
        chk("badmode_busy", 64'(busy), 0);
        chk("badmode_swap", 64'(swap), 0);
        tick();
        chk("badmode_seg", 64'(segment), 0);

        // Reset while waiting discards the request.
        tmode = 8'h01; tval = sys_time; req_segment = 1;
        update = 1; tick(); update = 0; tick();
        chk("prerst_seg", 64'(segment), 1);
        tval = 100000; req_segment = 0; update = 1; tick(); update = 0;
        chk("prerst_busy", 64'(busy), 1);
        rst = 1; tick(); rst = 0;
        chk("rstwait_seg", 64'(segment), 0);
        chk("rstwait_busy", 64'(busy), 0);
        sys_time = 200000; tick(); tick();
        chk("rstwait_busy_after", 64'(busy), 0);
        chk("rstwait_swap_after", 64'(swap), 0);

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            update      = ($urandom_range(0, 7) == 0);
            req_segment = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       tmode = 8'h00;
                1:       tmode = 8'h01;
                2:       tmode = 8'h02;
                3:       tmode = 8'hF0;
                4:       tmode = 8'h05;
                default: tmode = 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) begin
                rep0 = RW'($urandom_range(0, 3));
                rep1 = RW'($urandom_range(0, 3));
            end
            sys_time = sys_time + TW'($urandom_range(0, 3));
            tval = (tmode == 8'h02) ? TW'($urandom_range(0, 3))
                                    : sys_time + TW'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) gpio_in = 4'($urandom_range(0, 15));
            loop_end = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst = 0; update = 0; loop_end = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/segment_transition_ctl.md
Name: segment_transition_ctl

Overview:
- Schedules the active read segment (0/1) of one double-buffered sequencer: the modulation or STM datapath.
- Latches a segment-change request from the controller register file, then waits for the configured transition condition: sync index, system time, GPIO edge or external auto-swap.
- Counts completed loops against the segment's repeat count and raises STOP when a finite repeat count is exhausted.
- One instance sits between the controller register block and each segment index counter (MOD and STM).

Parameters:
- RepWidth, 16, width of the repeat-count fields. An all-ones value means infinite repeat.
- TimeWidth, 64, width of the system-time input and the transition value.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- UPDATE  in  1  one-cycle pulse; samples REQ_SEGMENT, TRANSITION_MODE and TRANSITION_VALUE.
- REQ_SEGMENT  in  1  requested read segment.
- REP0  in  RepWidth  repeat count of segment 0; loops played = REP0+1.
- REP1  in  RepWidth  repeat count of segment 1.
- TRANSITION_MODE  in  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT.
- TRANSITION_VALUE  in  TimeWidth  target time (SYS_TIME) or pin select in bits [1:0] (GPIO).
- SYS_TIME  in  TimeWidth  free-running synchronized system time.
- GPIO_IN  in  4  asynchronous-free GPIO inputs, already synchronized.
- LOOP_END  in  1  pulse from the index counter when the active segment's index wraps from cycle-1 to 0.
- SEGMENT  out  1  active read segment.
- SWAP  out  1  one-cycle pulse in the cycle SEGMENT changes or a restart occurs; the index counter clears on it.
- STOP  out  1  finite repeats exhausted; the index counter holds its last index.
- BUSY  out  1  transition pending.
- LOOP_CNT  out  RepWidth  completed loops of the active segment.

Behaviour:
- Reset state:
  - SEGMENT=0, SWAP=0, STOP=0, BUSY=0, LOOP_CNT=0.
  - Latched repeat count = all-ones (infinite). EXT flag = 0. State = RUN.
  - RST mid-wait discards the pending request.
- States: RUN, WAIT.
  - Outputs are registered.
  - Trigger condition true in cycle N -> SEGMENT/SWAP updated in cycle N+1.
- UPDATE with a valid mode:
  - Latches target segment, mode and value.
  - Clears the EXT flag. Enters WAIT, BUSY=1.
  - UPDATE while in WAIT replaces the pending request (latest wins).
  - UPDATE with an undefined mode is ignored entirely; state and outputs are unchanged.
- Trigger conditions in WAIT, evaluated from the cycle after UPDATE:
  - SYNC_IDX: next LOOP_END. If STOP=1, triggers immediately.
  - SYS_TIME: SYS_TIME >= latched value, unsigned. A time already passed triggers in the first WAIT cycle.
  - GPIO: rising edge of GPIO_IN[value[1:0]]. The edge register is initialized at UPDATE, so a pin already high does not trigger.
  - EXT: triggers immediately and sets the EXT flag.
- On trigger:
  - SEGMENT <= target, SWAP=1 for one cycle.
  - LOOP_CNT <= 0, STOP <= 0.
  - Latched repeat count <= REP of the target segment.
  - BUSY <= 0, state RUN.
  - A target equal to the current SEGMENT still pulses SWAP (restart).
- Loop counting, on LOOP_END, in RUN and in WAIT, for the current segment:
  - Latched rep all-ones: LOOP_CNT saturates at max; STOP never set.
  - LOOP_CNT == latched rep: segment completed.
    - EXT flag=0: STOP <= 1; LOOP_CNT holds.
    - EXT flag=1: auto-swap next cycle to the other segment with that segment's REP; SWAP pulses; EXT flag retained.
  - Otherwise: LOOP_CNT <= LOOP_CNT+1.
  - LOOP_END while STOP=1 is ignored.
- Simultaneous events:
  - UPDATE and LOOP_END in the same cycle: the loop is counted for the current segment. The SYNC_IDX trigger cannot fire in that same cycle; it waits for the next LOOP_END.
  - Trigger and LOOP_END in the same cycle: the trigger wins; the counter is reset.
- Only the initial segment 0 after reset plays forever regardless of REP0, until the first UPDATE.

Test Plan:
- Reset check: RST held 2 cycles -> SEGMENT=0, STOP=0, BUSY=0, LOOP_CNT=0; 100 LOOP_END pulses -> STOP stays 0.
- SYNC_IDX:
  - Stimulus: UPDATE REQ_SEGMENT=1, REP1=2, mode 0x00; LOOP_END at cycle +10.
  - SWAP and SEGMENT=1 at cycle +11.
  - Three further LOOP_END pulses -> LOOP_CNT 1, 2, then STOP=1 on the third.
  - A 4th LOOP_END -> no change.
- SYS_TIME: value=1000, SYS_TIME ramping from 990 -> SEGMENT switches the cycle after SYS_TIME=1000, BUSY high until then. A value of 500 (already past) -> switches 2 cycles after UPDATE.
- GPIO: mode 0x02, value=2, GPIO_IN[2] high at UPDATE -> no switch. Low then high -> switch the cycle after the rising edge. Toggling GPIO_IN[1] -> ignored.
- EXT: REP0=0, REP1=1, UPDATE seg 1 mode 0xF0 -> immediate switch to 1. Two LOOP_ENDs -> switch to 0. One LOOP_END -> back to 1. STOP never set.
- Corner cases:
  - UPDATE seg 1 SYNC_IDX, then UPDATE seg 0 SYS_TIME before any LOOP_END -> the first request is discarded.
  - UPDATE with mode 0x05 -> ignored.
  - RST during WAIT -> SEGMENT=0, BUSY=0.
